// File: rtl/product_accumulator.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : product_accumulator                                         |
// | Description : Sums a programmed number of unsigned products into a wide   |
// |               accumulator and holds the result on a valid/ready output.   |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module product_accumulator #(
    parameter int IN_W  = 8,
    parameter int ACC_W = 16,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  product,
    output logic [ACC_W-1:0] sum,
    output logic             sum_valid,
    input  logic             out_ready,
    output logic             overflow,
    output logic             busy
);

    localparam logic [1:0] c_s_idle  = 2'd0;
    localparam logic [1:0] c_s_accum = 2'd1;
    localparam logic [1:0] c_s_done  = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [LEN_W-1:0] r_remaining;
    logic [LEN_W-1:0] w_remaining_next;
    logic             r_overflow;
    logic             w_overflow_next;
    logic [ACC_W:0]   w_add;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign w_add = {1'b0, r_acc} + {{(ACC_W + 1 - IN_W){1'b0}}, product};

    always_comb begin
        w_state_next     = r_state;
        w_acc_next       = r_acc;
        w_remaining_next = r_remaining;
        w_overflow_next  = r_overflow;
        case (r_state)
            c_s_idle: begin
                if (start) begin
                    w_acc_next       = '0;
                    w_overflow_next  = 1'b0;
                    w_remaining_next = len;
                    w_state_next     = (len == '0) ? c_s_done : c_s_accum;
                end
            end
            c_s_accum: begin
                if (in_valid) begin
                    w_acc_next       = w_add[ACC_W-1:0];
                    w_overflow_next  = r_overflow | w_add[ACC_W];
                    w_remaining_next = r_remaining - LEN_W'(1);
                    if (r_remaining == LEN_W'(1)) begin
                        w_state_next = c_s_done;
                    end
                end
            end
            c_s_done: begin
                if (out_ready) begin
                    w_state_next = c_s_idle;
                end
            end
            default: begin
                w_state_next = c_s_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_s_idle;
            r_acc       <= '0;
            r_remaining <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_acc       <= w_acc_next;
            r_remaining <= w_remaining_next;
            r_overflow  <= w_overflow_next;
        end
    end

    assign in_ready  = (r_state == c_s_accum);
    assign sum_valid = (r_state == c_s_done);
    assign busy      = (r_state != c_s_idle);
    assign sum       = r_acc;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
